// File: rtl/stash_to_dram.sv
// stash_to_dram
//   Write-back packer between the stash eviction port and the DRAM write
//   path. One whole bucket (ORAMZ blocks of BlkSize_BEDChunks flits) is
//   captured first, because on DRAM the header comes before the payload.
//   The bucket is then emitted as HdrFlits header flits, most-significant
//   chunk first, followed by the payload flits in arrival order.
//
//   Handshake rule for both ports: a flit moves on a rising edge where
//   Valid && Ready are both high. The producer holds its data stable while
//   Valid is high and Ready is low. StashReady is high only in FILL.
//   DRAMValid is high only in HEADER and PAYLOAD.
//
//   Optional feature macro: ORAM_MAC_EN
//     defined   -> StashMAC port exists and the per-block MACs (H field)
//                  are appended to the header
//     undefined -> no StashMAC port and no H field
//
// Ports
//   Clock, Reset      clock; asynchronous active-low reset
//   StashData/Valid/Ready                     stash flit stream
//   StashPAddr/Leaf/BlockValid[/StashMAC]     per-block metadata, taken on flit 0
//   BucketIV          bucket IV, taken on flit 0 of block 0
//   DRAMData/Valid/Ready                      bucket flit stream to DRAM
//   PathTransition    1-cycle pulse after the last flit of a path
//   DbgState          current FSM state (0 FILL, 1 HEADER, 2 PAYLOAD)
module stash_to_dram #(
    parameter int BEDWidth          = 64,
    parameter int ORAMU             = 32,
    parameter int ORAML             = 32,
    parameter int ORAMZ             = 4,
    parameter int ORAMH             = 64,
    parameter int AESEntropy        = 64,
    parameter int BlkSize_BEDChunks = 8,
    parameter int PathBuckets       = 33
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [BEDWidth-1:0]   StashData,
    input  logic                  StashValid,
    output logic                  StashReady,
    input  logic [ORAMU-1:0]      StashPAddr,
    input  logic [ORAML-1:0]      StashLeaf,
    input  logic                  StashBlockValid,
`ifdef ORAM_MAC_EN
    input  logic [ORAMH-1:0]      StashMAC,
`endif
    input  logic [AESEntropy-1:0] BucketIV,
    output logic [BEDWidth-1:0]   DRAMData,
    output logic                  DRAMValid,
    input  logic                  DRAMReady,
    output logic                  PathTransition,
    output logic [1:0]            DbgState
);

    localparam int BufFlits = ORAMZ * BlkSize_BEDChunks;
`ifdef ORAM_MAC_EN
    localparam int RHRaw = AESEntropy + ORAMZ + ORAMZ * (ORAMU + ORAML) + ORAMZ * ORAMH;
`else
    localparam int RHRaw = AESEntropy + ORAMZ + ORAMZ * (ORAMU + ORAML);
`endif
    localparam int HdrFlits = (RHRaw + BEDWidth - 1) / BEDWidth;
    localparam int RHWidth  = HdrFlits * BEDWidth;

    localparam int FlitW = (BlkSize_BEDChunks > 1) ? $clog2(BlkSize_BEDChunks) : 1;
    localparam int BlkW  = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
    localparam int HdrW  = (HdrFlits > 1) ? $clog2(HdrFlits) : 1;
    localparam int RdW   = (BufFlits > 1) ? $clog2(BufFlits) : 1;
    localparam int BktW  = (PathBuckets > 1) ? $clog2(PathBuckets) : 1;

    localparam logic [FlitW-1:0] FlitLast = FlitW'(BlkSize_BEDChunks - 1);
    localparam logic [BlkW-1:0]  BlkLast  = BlkW'(ORAMZ - 1);
    localparam logic [HdrW-1:0]  HdrLast  = HdrW'(HdrFlits - 1);
    localparam logic [RdW-1:0]   RdLast   = RdW'(BufFlits - 1);
    localparam logic [BktW-1:0]  BktLast  = BktW'(PathBuckets - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [FlitW-1:0]         flit_q, flit_d;
    logic [BlkW-1:0]          blk_q, blk_d;
    logic [HdrW-1:0]          hdr_q, hdr_d;
    logic [RdW-1:0]           rd_q, rd_d;
    logic [BktW-1:0]          bkt_q, bkt_d;
    logic [AESEntropy-1:0]    iv_q, iv_d;
    logic [ORAMZ-1:0]         v_q, v_d;
    logic [ORAMZ*ORAMU-1:0]   u_q, u_d;
    logic [ORAMZ*ORAML-1:0]   l_q, l_d;
`ifdef ORAM_MAC_EN
    logic [ORAMZ*ORAMH-1:0]   h_q, h_d;
`endif
    logic                     path_transition_q, path_transition_d;

    // Payload buffer: no reset, contents are don't-care until written.
    logic [BEDWidth-1:0]      buf_q [BufFlits];
    logic                     wr_en;
    logic [RdW-1:0]           wr_idx;
    logic [BlkW-1:0]          slot;

    // Header image, zero-padded to a whole number of flits.
    logic [RHWidth-1:0]       header;
`ifdef ORAM_MAC_EN
    assign header = RHWidth'({h_q, l_q, u_q, v_q, iv_q});
`else
    assign header = RHWidth'({l_q, u_q, v_q, iv_q});
`endif

    // Chunk table, padded to a power of two so any counter value indexes it.
    logic [BEDWidth-1:0] hdr_chunks [2**HdrW];
    for (genvar gi = 0; gi < 2**HdrW; gi++) begin : g_chunk
        if (gi < HdrFlits) begin : g_real
            // Flit 0 carries the most-significant chunk of the header.
            assign hdr_chunks[gi] = header[RHWidth-1-gi*BEDWidth -: BEDWidth];
        end else begin : g_pad
            assign hdr_chunks[gi] = '0;
        end
    end

    assign wr_idx = RdW'(int'(blk_q) * BlkSize_BEDChunks + int'(flit_q));
    // The first block of the stream lands in the highest slot.
    assign slot   = BlkLast - blk_q;

    always_comb begin
        state_d           = state_q;
        flit_d            = flit_q;
        blk_d             = blk_q;
        hdr_d             = hdr_q;
        rd_d              = rd_q;
        bkt_d             = bkt_q;
        iv_d              = iv_q;
        v_d               = v_q;
        u_d               = u_q;
        l_d               = l_q;
`ifdef ORAM_MAC_EN
        h_d               = h_q;
`endif
        path_transition_d = 1'b0;
        wr_en             = 1'b0;
        StashReady        = 1'b0;
        DRAMValid         = 1'b0;
        DRAMData          = '0;

        case (state_q)
            FILL: begin
                StashReady = 1'b1;
                if (StashValid) begin
                    wr_en = 1'b1;
                    if (flit_q == '0) begin
                        v_d[slot]                          = StashBlockValid;
                        u_d[int'(slot)*ORAMU +: ORAMU]     = StashPAddr;
                        l_d[int'(slot)*ORAML +: ORAML]     = StashLeaf;
`ifdef ORAM_MAC_EN
                        h_d[int'(slot)*ORAMH +: ORAMH]     = StashMAC;
`endif
                        if (blk_q == '0) begin
                            iv_d = BucketIV;
                        end
                    end
                    if (flit_q == FlitLast) begin
                        flit_d = '0;
                        if (blk_q == BlkLast) begin
                            blk_d   = '0;
                            state_d = HEADER;
                        end else begin
                            blk_d = blk_q + 1'b1;
                        end
                    end else begin
                        flit_d = flit_q + 1'b1;
                    end
                end
            end

            HEADER: begin
                DRAMValid = 1'b1;
                DRAMData  = hdr_chunks[hdr_q];
                if (DRAMReady) begin
                    if (hdr_q == HdrLast) begin
                        hdr_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        hdr_d = hdr_q + 1'b1;
                    end
                end
            end

            PAYLOAD: begin
                DRAMValid = 1'b1;
                DRAMData  = buf_q[rd_q];
                if (DRAMReady) begin
                    if (rd_q == RdLast) begin
                        rd_d    = '0;
                        state_d = FILL;
                        if (bkt_q == BktLast) begin
                            bkt_d             = '0;
                            path_transition_d = 1'b1;
                        end else begin
                            bkt_d = bkt_q + 1'b1;
                        end
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q           <= FILL;
            flit_q            <= '0;
            blk_q             <= '0;
            hdr_q             <= '0;
            rd_q              <= '0;
            bkt_q             <= '0;
            iv_q              <= '0;
            v_q               <= '0;
            u_q               <= '0;
            l_q               <= '0;
`ifdef ORAM_MAC_EN
            h_q               <= '0;
`endif
            path_transition_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            flit_q            <= flit_d;
            blk_q             <= blk_d;
            hdr_q             <= hdr_d;
            rd_q              <= rd_d;
            bkt_q             <= bkt_d;
            iv_q              <= iv_d;
            v_q               <= v_d;
            u_q               <= u_d;
            l_q               <= l_d;
`ifdef ORAM_MAC_EN
            h_q               <= h_d;
`endif
            path_transition_q <= path_transition_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            buf_q[wr_idx] <= StashData;
        end
    end

    assign PathTransition = path_transition_q;
    assign DbgState       = state_q;

endmodule

// File: tb/tb_stash_to_dram.sv
// Directed bench for stash_to_dram (Z=4, BlkSize=8, 64-bit flits,
// PathBuckets overridden to 3). Header flit values are hand-derived for
// PAddr = 0x100+k and Leaf = 0x200+k (and MAC = 0xC0+k with ORAM_MAC_EN).
module tb_stash_to_dram;
  localparam int W = 64;
`ifdef ORAM_MAC_EN
  localparam int HDR = 10;
`else
  localparam int HDR = 6;
`endif
  localparam int BEATS = HDR + 32;

  logic          Clock;
  logic          Reset;
  logic [W-1:0]  StashData;
  logic          StashValid;
  logic          StashReady;
  logic [31:0]   StashPAddr;
  logic [31:0]   StashLeaf;
  logic          StashBlockValid;
`ifdef ORAM_MAC_EN
  logic [63:0]   StashMAC;
`endif
  logic [63:0]   BucketIV;
  logic [W-1:0]  DRAMData;
  logic          DRAMValid;
  logic          DRAMReady;
  logic          PathTransition;
  logic [1:0]    DbgState;

  int n_cmp = 0;
  int n_fail = 0;
  int pt_count = 0;
  logic [W-1:0] exp_q[$];

  stash_to_dram #(.PathBuckets(3)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .StashData(StashData),
    .StashValid(StashValid),
    .StashReady(StashReady),
    .StashPAddr(StashPAddr),
    .StashLeaf(StashLeaf),
    .StashBlockValid(StashBlockValid),
`ifdef ORAM_MAC_EN
    .StashMAC(StashMAC),
`endif
    .BucketIV(BucketIV),
    .DRAMData(DRAMData),
    .DRAMValid(DRAMValid),
    .DRAMReady(DRAMReady),
    .PathTransition(PathTransition),
    .DbgState(DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (PathTransition === 1'b1) pt_count++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-derived header flits, most-significant chunk first.
  function automatic logic [W-1:0] hdr_flit(input int i, input logic [3:0] v, input logic [63:0] iv);
    int j;
    j = i - (HDR - 6);
    case (j)
      -4:      return 64'h0;
      -3:      return 64'h0000_0000_0000_0C00;
      -2:      return 64'h0000_0000_0000_0C10;
      -1:      return 64'h0000_0000_0000_0C20;
      0:       return (HDR == 10) ? 64'h0000_0000_0000_0C30 : 64'h0;
      1:       return 64'h0000_2000_0000_2010;
      2:       return 64'h0000_2020_0000_2030;
      3:       return 64'h0000_1000_0000_1010;
      4:       return 64'h0000_1020_0000_1030 | {60'h0, v};
      default: return iv;
    endcase
  endfunction

  task automatic push_bucket_exp(input logic [3:0] v, input logic [63:0] iv, input logic [W-1:0] d0);
    for (int i = 0; i < HDR; i++) exp_q.push_back(hdr_flit(i, v, iv));
    for (int i = 0; i < 32; i++) exp_q.push_back(d0 + W'(i));
  endtask

  // ---------------- drivers ----------------
  // Sends nflits stash flits; metadata is real only on each block's flit 0.
  task automatic send_flits(input int nflits, input logic [31:0] pbase, input logic [3:0] dummy,
                            input logic [63:0] iv, input logic [W-1:0] d0);
    int b;
    int f;
    for (int n = 0; n < nflits; n++) begin
      b = n / 8;
      f = n % 8;
      @(negedge Clock);
      if (f == 0) check("stash_ready_fill", {63'h0, StashReady}, 64'h1);
      StashValid = 1'b1;
      StashData  = d0 + W'(n);
      if (f == 0) begin
        StashPAddr      = pbase + 32'(b);
        StashLeaf       = pbase + 32'h100 + 32'(b);
        StashBlockValid = ~dummy[b];
`ifdef ORAM_MAC_EN
        StashMAC        = 64'hC0 + 64'(b);
`endif
        BucketIV        = (b == 0) ? iv : {$urandom, $urandom};
      end else begin
        StashPAddr      = $urandom;
        StashLeaf       = $urandom;
        StashBlockValid = 1'($urandom_range(0, 1));
`ifdef ORAM_MAC_EN
        StashMAC        = {$urandom, $urandom};
`endif
        BucketIV        = {$urandom, $urandom};
      end
    end
    @(negedge Clock);
    StashValid = 1'b0;
    StashData  = {$urandom, $urandom};
  endtask

  // Starts at a negedge in HEADER, consumes exp_q, ends at the negedge
  // after the final beat was consumed.
  task automatic drain(input bit toggle, output int cyc);
    bit prev_stall;
    bit ready_bad;
    bit ph;
    logic [W-1:0] held;
    cyc = 0;
    prev_stall = 1'b0;
    ready_bad = 1'b0;
    ph = 1'b1;
    held = '0;
    while (exp_q.size() > 0 && cyc < 400) begin
      DRAMReady = toggle ? ph : 1'b1;
      ph = ~ph;
      // Stash stays stalled for the full drain even if it offers flits.
      StashValid = 1'($urandom_range(0, 1));
      if (StashReady !== 1'b0) ready_bad = 1'b1;
      check("dram_valid_drain", {63'h0, DRAMValid}, 64'h1);
      if (prev_stall) check("held_data", DRAMData, held);
      if (DRAMValid === 1'b1 && DRAMReady) begin
        check("beat", DRAMData, exp_q.pop_front());
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        held = DRAMData;
      end
      @(negedge Clock);
      cyc++;
    end
    StashValid = 1'b0;
    DRAMReady = 1'b1;
    check("drain_all_beats_left", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    check("stash_ready_low_drain", {63'h0, ready_bad}, 64'h0);
  endtask

  task automatic full_bucket(input logic [3:0] dummy, input logic [3:0] v, input logic [63:0] iv,
                             input logic [W-1:0] d0, input bit toggle, input bit pt_exp);
    int cyc;
    push_bucket_exp(v, iv, d0);
    send_flits(32, 32'h100, dummy, iv, d0);
    check("header_entry_stash_ready", {63'h0, StashReady}, 64'h0);
    check("header_entry_dram_valid", {63'h0, DRAMValid}, 64'h1);
    check("header_entry_state", {62'h0, DbgState}, 64'h1);
    drain(toggle, cyc);
    check("drain_cycles", 64'(cyc), toggle ? 64'(2 * BEATS - 1) : 64'(BEATS));
    check("post_drain_dram_valid", {63'h0, DRAMValid}, 64'h0);
    check("post_drain_stash_ready", {63'h0, StashReady}, 64'h1);
    check("path_transition", {63'h0, PathTransition}, {63'h0, pt_exp});
    @(negedge Clock);
    check("path_transition_after", {63'h0, PathTransition}, 64'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b0;
    StashData = '0;
    StashValid = 1'b0;
    StashPAddr = '0;
    StashLeaf = '0;
    StashBlockValid = 1'b0;
`ifdef ORAM_MAC_EN
    StashMAC = '0;
`endif
    BucketIV = '0;
    DRAMReady = 1'b1;
    repeat (3) @(negedge Clock);
    check("reset_stash_ready", {63'h0, StashReady}, 64'h1);
    check("reset_dram_valid", {63'h0, DRAMValid}, 64'h0);
    check("reset_path_transition", {63'h0, PathTransition}, 64'h0);
    check("reset_state", {62'h0, DbgState}, 64'h0);
    Reset = 1'b1;

    // 1: all real, IV 0xA5, payload 0..31 (bucket 0 of path)
    full_bucket(4'b0000, 4'hF, 64'hA5, 64'd0, 1'b0, 1'b0);
    // 2: blocks 1 and 3 dummy -> V = 4'b1010 (bucket 1)
    full_bucket(4'b1010, 4'b1010, 64'h1234_5678_9ABC_DEF0, 64'h1000, 1'b0, 1'b0);
    // 3: DRAMReady toggling; bucket 2 closes the 3-bucket path
    full_bucket(4'b0000, 4'hF, 64'hDEAD_0000_BEEF_0001, 64'h2000, 1'b1, 1'b1);

    // 5: reset after 20 flits of a bucket with foreign metadata
    send_flits(20, 32'h900, 4'b1111, 64'h77, 64'h9000);
    Reset = 1'b0;
    #1;
    check("midfill_reset_dram_valid", {63'h0, DRAMValid}, 64'h0);
    check("midfill_reset_stash_ready", {63'h0, StashReady}, 64'h1);
    check("midfill_reset_state", {62'h0, DbgState}, 64'h0);
    @(negedge Clock);
    Reset = 1'b1;

    // Reset while in HEADER drops DRAMValid at once.
    send_flits(32, 32'h900, 4'b0000, 64'h66, 64'h9100);
    check("pre_reset_dram_valid", {63'h0, DRAMValid}, 64'h1);
    Reset = 1'b0;
    #1;
    check("header_reset_dram_valid", {63'h0, DRAMValid}, 64'h0);
    check("header_reset_stash_ready", {63'h0, StashReady}, 64'h1);
    @(negedge Clock);
    Reset = 1'b1;

    // 4: three clean buckets, exactly one PathTransition after the third
    pt_count = 0;
    full_bucket(4'b0000, 4'hF, 64'h0102_0304_0506_0708, 64'h3000, 1'b0, 1'b0);
    full_bucket(4'b1111, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000, 1'b0, 1'b0);
    full_bucket(4'b0110, 4'b1001, 64'h5A5A_0000_0000_A5A5, 64'h5000, 1'b0, 1'b1);
    repeat (3) @(negedge Clock);
    check("path_transition_count", 64'(pt_count), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
